// File: rtl/eth_mac_conf_ctrl_pkg.sv
// Shared widths, vector bit map, FSM states and config payload for the MAC config sequencer.
package eth_mac_conf_ctrl_pkg;

   localparam int unsigned MAC_W = 48;
   localparam int unsigned LEN_W = 15;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned VEC_W = 80;

   // Configuration vector bit positions (shared by TX and RX)
   localparam int unsigned VEC_MAC_LSB = 32;
   localparam int unsigned VEC_LEN_LSB = 16;
   localparam int unsigned VEC_CHK_HI  = 9;
   localparam int unsigned VEC_CHK_LO  = 8;
   localparam int unsigned VEC_JUMBO   = 4;
   localparam int unsigned VEC_VLAN    = 2;
   localparam int unsigned VEC_EN      = 1;

   localparam logic [MAC_W-1:0] DEF_SRC_MAC = 48'h001122334455;
   localparam logic [LEN_W-1:0] DEF_MAX_LEN = 15'd1518;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_DISABLE = 3'd2,
      ST_APPLY   = 3'd3,
      ST_ENABLE  = 3'd4
   } state_e;

   typedef struct packed {
      logic [MAC_W-1:0] mac;
      logic [LEN_W-1:0] max_len;
      logic             jumbo;
      logic             vlan;
      logic             tx_en;
      logic             rx_en;
      logic             rx_chk_dis;
   } cfg_t;

   // Assemble one 80-bit configuration vector; every unmapped bit is 0
   function automatic logic [VEC_W-1:0] pack_vec(
      input logic [MAC_W-1:0] mac,
      input logic [LEN_W-1:0] max_len,
      input logic             jumbo,
      input logic             vlan,
      input logic             en,
      input logic             chk_dis
   );
      logic [VEC_W-1:0] v;
      v = '0;
      v[VEC_MAC_LSB +: MAC_W] = mac;
      v[VEC_LEN_LSB +: LEN_W] = max_len;
      v[VEC_CHK_HI]           = chk_dis;
      v[VEC_CHK_LO]           = chk_dis;
      v[VEC_JUMBO]            = jumbo;
      v[VEC_VLAN]             = vlan;
      v[VEC_EN]               = en;
      return v;
   endfunction

endpackage

// File: rtl/eth_mac_conf_ctrl_frame_tracker.sv
// Tracks whether a stream is between the first and last beat of a frame.
module eth_mac_conf_ctrl_frame_tracker (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_beat,
   input  logic i_last,
   output logic o_idle_c
);

   logic r_in_frame;

   // Set on a non-last beat, cleared on a last beat; single-beat frames never set it
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_in_frame <= 1'b0;
      end else if (i_beat) begin
         r_in_frame <= ~i_last;
      end
   end

   // Idle only when no frame is open and nothing is transferring this cycle
   assign o_idle_c = ~r_in_frame & ~i_beat;

endmodule

// File: rtl/eth_mac_conf_ctrl.sv
// Runtime sequencer that swaps the MAC TX/RX configuration vectors only between frames.
module eth_mac_conf_ctrl
   import eth_mac_conf_ctrl_pkg::*;
#(
   parameter logic [MAC_W-1:0] SRC_MAC       = DEF_SRC_MAC,
   parameter logic [LEN_W-1:0] MAX_LEN       = DEF_MAX_LEN,
   parameter int unsigned      SETTLE_CYC    = 16,
   parameter int unsigned      DRAIN_TIMEOUT = 65535
) (
   input  logic             clk156,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [MAC_W-1:0] req_src_mac,
   input  logic [LEN_W-1:0] req_max_len,
   input  logic             req_jumbo,
   input  logic             req_vlan,
   input  logic             req_tx_en,
   input  logic             req_rx_en,
   input  logic             req_rx_chk_dis,
   input  logic             tx_axis_tvalid,
   input  logic             tx_axis_tready,
   input  logic             tx_axis_tlast,
   input  logic             rx_axis_tvalid,
   input  logic             rx_axis_tlast,
   output logic             tx_gate,
   output logic [VEC_W-1:0] mac_tx_configuration_vector,
   output logic [VEC_W-1:0] mac_rx_configuration_vector,
   output logic             busy,
   output logic             done_pulse,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   cfg_t             r_shadow;
   cfg_t             w_req;

   logic [MAC_W-1:0] r_mac;
   logic [LEN_W-1:0] r_max_len;
   logic             r_jumbo;
   logic             r_vlan;
   logic             r_tx_en;
   logic             r_rx_en;
   logic             r_rx_chk;

   logic             r_req_ready;
   logic             r_tx_gate;
   logic             r_busy;
   logic             r_done;
   logic             r_timeout;

   logic             w_tx_idle_c;
   logic             w_rx_idle_c;
   logic             w_link_idle_c;

   assign w_req = '{mac:        req_src_mac,
                    max_len:    req_max_len,
                    jumbo:      req_jumbo,
                    vlan:       req_vlan,
                    tx_en:      req_tx_en,
                    rx_en:      req_rx_en,
                    rx_chk_dis: req_rx_chk_dis};

   eth_mac_conf_ctrl_frame_tracker u_tx_trk (
      .i_clk    (clk156),
      .i_reset  (reset),
      .i_beat   (tx_axis_tvalid & tx_axis_tready),
      .i_last   (tx_axis_tlast),
      .o_idle_c (w_tx_idle_c)
   );

   eth_mac_conf_ctrl_frame_tracker u_rx_trk (
      .i_clk    (clk156),
      .i_reset  (reset),
      .i_beat   (rx_axis_tvalid),
      .i_last   (rx_axis_tlast),
      .o_idle_c (w_rx_idle_c)
   );

   assign w_link_idle_c = w_tx_idle_c & w_rx_idle_c;

   // Sequencer FSM with drain/settle counter, request shadow and registered outputs
   always_ff @(posedge clk156) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_shadow    <= '0;
         r_mac       <= SRC_MAC;
         r_max_len   <= MAX_LEN;
         r_jumbo     <= 1'b0;
         r_vlan      <= 1'b0;
         r_tx_en     <= 1'b1;
         r_rx_en     <= 1'b1;
         r_rx_chk    <= 1'b1;
         r_req_ready <= 1'b1;
         r_tx_gate   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_shadow    <= w_req;
                  r_timeout   <= 1'b0;
                  r_cnt       <= '0;
                  r_req_ready <= 1'b0;
                  r_tx_gate   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_link_idle_c || (r_cnt == DRAIN_LAST)) begin
                  // Forced apply when the link never goes quiet
                  if (!w_link_idle_c) begin
                     r_timeout <= 1'b1;
                  end
                  r_tx_en <= 1'b0;
                  r_rx_en <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ST_DISABLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DISABLE: begin
               if (r_cnt == SETTLE_LAST) begin
                  r_mac     <= r_shadow.mac;
                  r_max_len <= r_shadow.max_len;
                  r_jumbo   <= r_shadow.jumbo;
                  r_vlan    <= r_shadow.vlan;
                  r_rx_chk  <= r_shadow.rx_chk_dis;
                  r_cnt     <= '0;
                  r_state   <= ST_APPLY;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_APPLY: begin
               r_tx_en <= r_shadow.tx_en;
               r_rx_en <= r_shadow.rx_en;
               r_done  <= 1'b1;
               r_cnt   <= '0;
               r_state <= ST_ENABLE;
            end
            ST_ENABLE: begin
               r_done      <= 1'b0;
               r_tx_gate   <= 1'b0;
               r_busy      <= 1'b0;
               r_req_ready <= 1'b1;
               r_cnt       <= '0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign tx_gate    = r_tx_gate;
   assign busy       = r_busy;
   assign done_pulse = r_done;
   assign timeout    = r_timeout;

   assign mac_tx_configuration_vector = pack_vec(r_mac, r_max_len, r_jumbo, r_vlan, r_tx_en, 1'b0);
   assign mac_rx_configuration_vector = pack_vec(r_mac, r_max_len, r_jumbo, r_vlan, r_rx_en, r_rx_chk);

endmodule

// File: tb/tb_eth_mac_conf_ctrl.sv
// Directed/randomized bench for eth_mac_conf_ctrl with a phase-based reference model.
module tb_eth_mac_conf_ctrl;

   localparam int SC        = 16;
   localparam int DT        = 100;
   localparam int TX_LAST_J = 29;

   typedef struct packed {
      logic [47:0] mac;
      logic [14:0] len;
      logic        jumbo;
      logic        vlan;
      logic        tx_en;
      logic        rx_en;
      logic        chk;
   } req_t;

   logic        clk156 = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [47:0] req_src_mac;
   logic [14:0] req_max_len;
   logic        req_jumbo;
   logic        req_vlan;
   logic        req_tx_en;
   logic        req_rx_en;
   logic        req_rx_chk_dis;
   logic        tx_axis_tvalid;
   logic        tx_axis_tready;
   logic        tx_axis_tlast;
   logic        rx_axis_tvalid;
   logic        rx_axis_tlast;
   logic        tx_gate;
   logic [79:0] mac_tx_configuration_vector;
   logic [79:0] mac_rx_configuration_vector;
   logic        busy;
   logic        done_pulse;
   logic        timeout;

   int          n_vec = 0;
   int          n_err = 0;
   logic [79:0] cur_tx;
   logic [79:0] cur_rx;

   localparam logic [79:0] RST_TX = {48'h001122334455, 1'b0, 15'd1518, 14'b0, 2'b10};
   localparam logic [79:0] RST_RX = {48'h001122334455, 1'b0, 15'd1518, 6'b0, 2'b11, 6'b0, 2'b10};

   always #5 clk156 = ~clk156;

   eth_mac_conf_ctrl #(
      .SETTLE_CYC    (SC),
      .DRAIN_TIMEOUT (DT)
   ) dut (
      .clk156                      (clk156),
      .reset                       (reset),
      .req_valid                   (req_valid),
      .req_ready                   (req_ready),
      .req_src_mac                 (req_src_mac),
      .req_max_len                 (req_max_len),
      .req_jumbo                   (req_jumbo),
      .req_vlan                    (req_vlan),
      .req_tx_en                   (req_tx_en),
      .req_rx_en                   (req_rx_en),
      .req_rx_chk_dis              (req_rx_chk_dis),
      .tx_axis_tvalid              (tx_axis_tvalid),
      .tx_axis_tready              (tx_axis_tready),
      .tx_axis_tlast               (tx_axis_tlast),
      .rx_axis_tvalid              (rx_axis_tvalid),
      .rx_axis_tlast               (rx_axis_tlast),
      .tx_gate                     (tx_gate),
      .mac_tx_configuration_vector (mac_tx_configuration_vector),
      .mac_rx_configuration_vector (mac_rx_configuration_vector),
      .busy                        (busy),
      .done_pulse                  (done_pulse),
      .timeout                     (timeout)
   );

   // Expected vector straight from the documented bit map
   function automatic logic [79:0] mk_vec(input req_t c, input logic en, input logic is_rx);
      logic [1:0] chk;
      chk = is_rx ? {c.chk, c.chk} : 2'b00;
      return {c.mac, 1'b0, c.len, 6'b0, chk, 3'b0, c.jumbo, 1'b0, c.vlan, en, 1'b0};
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.mac   = {16'($urandom), 32'($urandom)};
      r.len   = 15'($urandom_range(64, 16383));
      r.jumbo = 1'($urandom);
      r.vlan  = 1'($urandom);
      r.tx_en = 1'($urandom);
      r.rx_en = 1'($urandom);
      r.chk   = 1'($urandom);
      return r;
   endfunction

   task automatic chk_v(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk156);
      #1;
   endtask

   task automatic put_req(input req_t c);
      req_src_mac    = c.mac;
      req_max_len    = c.len;
      req_jumbo      = c.jumbo;
      req_vlan       = c.vlan;
      req_tx_en      = c.tx_en;
      req_rx_en      = c.rx_en;
      req_rx_chk_dis = c.chk;
   endtask

   task automatic chk_reset_state(input string tag);
      chk_v({tag, "_txvec"}, mac_tx_configuration_vector, RST_TX);
      chk_v({tag, "_rxvec"}, mac_rx_configuration_vector, RST_RX);
      chk_b({tag, "_ready"}, req_ready, 1'b1);
      chk_b({tag, "_gate"}, tx_gate, 1'b0);
      chk_b({tag, "_busy"}, busy, 1'b0);
      chk_b({tag, "_done"}, done_pulse, 1'b0);
      chk_b({tag, "_tmo"}, timeout, 1'b0);
   endtask

   // One full sequence. Caller has put nc on the bus with req_valid=1 while idle.
   // mode 0: quiet link; mode 1: TX frame opened in the handshake cycle; mode 2: endless RX frame.
   // Observation j is taken just after the j-th edge following the handshake edge (j=0).
   task automatic run_seq(input req_t nc, input int mode, input bit hold, input req_t next_c);
      int d;
      int last;
      d    = (mode == 0) ? 1 : (mode == 1) ? TX_LAST_J + 2 : DT;
      last = d + SC + 2;
      tick();
      for (int j = 0; j <= last; j++) begin
         logic [79:0] etx;
         logic [79:0] erx;
         logic        erdy;
         if (j < d) begin
            etx = cur_tx;
            erx = cur_rx;
         end else if (j < d + SC) begin
            etx = cur_tx & ~80'd2;
            erx = cur_rx & ~80'd2;
         end else if (j == d + SC) begin
            etx = mk_vec(nc, 1'b0, 1'b0);
            erx = mk_vec(nc, 1'b0, 1'b1);
         end else begin
            etx = mk_vec(nc, nc.tx_en, 1'b0);
            erx = mk_vec(nc, nc.rx_en, 1'b1);
         end
         erdy = (j == last);
         chk_v($sformatf("m%0d_j%0d_txvec", mode, j), mac_tx_configuration_vector, etx);
         chk_v($sformatf("m%0d_j%0d_rxvec", mode, j), mac_rx_configuration_vector, erx);
         chk_b($sformatf("m%0d_j%0d_done", mode, j), done_pulse, (j == d + SC + 1));
         chk_b($sformatf("m%0d_j%0d_ready", mode, j), req_ready, erdy);
         chk_b($sformatf("m%0d_j%0d_busy", mode, j), busy, !erdy);
         chk_b($sformatf("m%0d_j%0d_gate", mode, j), tx_gate, !erdy);
         chk_b($sformatf("m%0d_j%0d_tmo", mode, j), timeout, (mode == 2) && (j >= d));
         if (j == 0) begin
            if (hold) begin
               put_req(next_c);
            end else begin
               put_req(rand_req());
               req_valid = 1'b0;
            end
         end
         if (mode == 1) begin
            if (j == TX_LAST_J) begin
               tx_axis_tvalid = 1'b1;
               tx_axis_tready = 1'b1;
               tx_axis_tlast  = 1'b1;
            end else begin
               tx_axis_tvalid = 1'($urandom);
               tx_axis_tready = 1'b0;
               tx_axis_tlast  = 1'($urandom);
            end
         end
         if (j < last) tick();
      end
      cur_tx = mk_vec(nc, nc.tx_en, 1'b0);
      cur_rx = mk_vec(nc, nc.rx_en, 1'b1);
   endtask

   initial begin
      req_t a;
      req_t b;
      reset          = 1'b1;
      req_valid      = 1'b0;
      put_req('0);
      tx_axis_tvalid = 1'b0;
      tx_axis_tready = 1'b0;
      tx_axis_tlast  = 1'b0;
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
      cur_tx         = RST_TX;
      cur_rx         = RST_RX;

      // Reset values, during and just after reset
      tick();
      tick();
      chk_reset_state("rst_on");
      reset = 1'b0;
      tick();
      chk_reset_state("rst_off");

      // Quiet link, jumbo request with 9000-byte max length
      a       = rand_req();
      a.len   = 15'd9000;
      a.jumbo = 1'b1;
      a.tx_en = 1'b1;
      a.rx_en = 1'b1;
      put_req(a);
      req_valid = 1'b1;
      run_seq(a, 0, 1'b0, a);
      chk_b("jumbo_bit", mac_tx_configuration_vector[4], 1'b1);

      // Random requests on a quiet link, including disabled directions
      for (int n = 0; n < 3; n++) begin
         tick();
         a = rand_req();
         put_req(a);
         req_valid = 1'b1;
         run_seq(a, 0, 1'b0, a);
      end

      // TX frame opened in the handshake cycle, tlast 30 cycles later
      tick();
      a = rand_req();
      put_req(a);
      req_valid      = 1'b1;
      tx_axis_tvalid = 1'b1;
      tx_axis_tready = 1'b1;
      tx_axis_tlast  = 1'b0;
      run_seq(a, 1, 1'b0, a);
      tx_axis_tvalid = 1'b0;
      tx_axis_tready = 1'b0;
      tx_axis_tlast  = 1'b0;

      // RX frame that never ends: forced apply after the drain timeout
      tick();
      a = rand_req();
      put_req(a);
      req_valid      = 1'b1;
      rx_axis_tvalid = 1'b1;
      rx_axis_tlast  = 1'b0;
      run_seq(a, 2, 1'b0, a);
      rx_axis_tlast = 1'b1;
      tick();
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
      tick();
      chk_b("tmo_sticky", timeout, 1'b1);

      // Request held during busy is accepted once idle and sequenced again
      a = rand_req();
      b = rand_req();
      put_req(a);
      req_valid = 1'b1;
      run_seq(a, 0, 1'b1, b);
      run_seq(b, 0, 1'b0, b);

      // Reset in the settle window discards the sequence
      tick();
      a = rand_req();
      put_req(a);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk_b("rst_mid_en_low", mac_tx_configuration_vector[1], 1'b0);
      chk_b("rst_mid_busy", busy, 1'b1);
      reset = 1'b1;
      tick();
      chk_reset_state("rst_mid");
      reset  = 1'b0;
      cur_tx = RST_TX;
      cur_rx = RST_RX;
      for (int k = 0; k < SC + 6; k++) begin
         tick();
         chk_b($sformatf("rst_after_k%0d_done", k), done_pulse, 1'b0);
         chk_b($sformatf("rst_after_k%0d_busy", k), busy, 1'b0);
         chk_v($sformatf("rst_after_k%0d_txvec", k), mac_tx_configuration_vector, RST_TX);
      end

      // Normal operation after the mid-sequence reset
      a = rand_req();
      put_req(a);
      req_valid = 1'b1;
      run_seq(a, 0, 1'b0, a);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
